spi_slave: RTL and testbench

SPI slave (target) endpoint that answers the team's `spi_master` over the same four-wire bus. It oversamples SCLK, MOSI and the select line in the system clock domain, drives MISO, and exchanges DATA_WIDTH-bit words with local logic through a one-deep transmit buffer and a held receive register. It supports back-to-back words within one select window. It reports per-frame completion, overrun, underrun and abort.

---
 rtl/spi_slave.sv | 183 ++++++++++++++++++
 tb/tb_spi_slave.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave.sv
// SPI target endpoint: oversamples the bus in the clk domain and exchanges
// DATA_WIDTH-bit words with local logic through a one-deep tx buffer.
module spi_slave #(
    parameter int MODE          = 3,
    parameter int DATA_WIDTH    = 32,
    parameter int MSB_FIRST     = 0,
    parameter int SS_ACTIVE_LOW = 0,
    parameter int MIN_HALF      = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  sclk,
    input  logic                  mosi,
    input  logic                  ss,
    output logic                  miso,
    output logic                  miso_oe,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_load,
    output logic                  tx_ready,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    input  logic                  rx_ack,
    input  logic                  clr_flags,
    output logic                  busy,
    output logic                  irq,
    output logic                  rx_overrun,
    output logic                  tx_underrun,
    output logic                  frame_abort
);
    localparam bit   CPOL    = MODE[1];
    localparam bit   CPHA    = MODE[0];
    localparam logic SS_IDLE = (SS_ACTIVE_LOW != 0);
    localparam int   CW      = $clog2(DATA_WIDTH);

    if (DATA_WIDTH < 2 || MIN_HALF < 1) begin : g_param_chk
        $error("spi_slave: DATA_WIDTH must be >= 2 and MIN_HALF >= 1");
    end

    typedef enum logic {ST_IDLE, ST_ACTIVE} state_t;

    state_t                r_state, w_state_nx;
    logic                  r_sclk_s1, r_sclk_s2, r_sclk_d;
    logic                  r_ss_s1, r_ss_s2;
    logic                  r_mosi_s1, r_mosi_s2;
    logic [1:0]            r_sync_ok;
    logic                  r_armed;
    logic [CW-1:0]         r_bit_cnt;
    logic                  r_words_done;
    logic [DATA_WIDTH-1:0] r_rx_sh, r_tx_sh, r_tx_buf;
    logic                  r_miso, r_irq;

    logic                  w_sel, w_lead, w_trail, w_sample_edge, w_shift_edge;
    logic                  w_enter, w_exit, w_do_sample, w_do_shift, w_word_start, w_word_end;
    logic [DATA_WIDTH-1:0] w_rx_next, w_tx_word, w_tx_shifted;

    function automatic logic first_bit(input logic [DATA_WIDTH-1:0] v);
        return (MSB_FIRST != 0) ? v[DATA_WIDTH-1] : v[0];
    endfunction

    assign w_sel         = (r_ss_s2 != SS_IDLE);
    assign w_lead        = (r_sclk_d == CPOL) && (r_sclk_s2 != CPOL);
    assign w_trail       = (r_sclk_d != CPOL) && (r_sclk_s2 == CPOL);
    assign w_sample_edge = CPHA ? w_trail : w_lead;
    assign w_shift_edge  = CPHA ? w_lead  : w_trail;
    assign w_word_end    = w_do_sample && (r_bit_cnt == CW'(DATA_WIDTH - 1));
    assign w_rx_next     = (MSB_FIRST != 0) ? {r_rx_sh[DATA_WIDTH-2:0], r_mosi_s2}
                                            : {r_mosi_s2, r_rx_sh[DATA_WIDTH-1:1]};
    assign w_tx_word     = tx_ready ? '0 : r_tx_buf;
    assign w_tx_shifted  = (MSB_FIRST != 0) ? (r_tx_sh << 1) : (r_tx_sh >> 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_nx;
    end

    // A shift edge with bit_cnt==0 begins a new word; in CPHA=0 only after a
    // completed word, since the first word was already started at select.
    always_comb begin
        w_state_nx   = r_state;
        w_enter      = 1'b0;
        w_exit       = 1'b0;
        w_do_sample  = 1'b0;
        w_do_shift   = 1'b0;
        w_word_start = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_sel && r_armed) begin
                    w_state_nx   = ST_ACTIVE;
                    w_enter      = 1'b1;
                    w_word_start = !CPHA;
                end
            end
            ST_ACTIVE: begin
                if (!w_sel) begin
                    w_state_nx = ST_IDLE;
                    w_exit     = 1'b1;
                end else begin
                    w_do_sample = w_sample_edge;
                    if (w_shift_edge) begin
                        if (r_bit_cnt != '0)               w_do_shift   = 1'b1;
                        else if (CPHA || r_words_done)     w_word_start = 1'b1;
                    end
                end
            end
            default: w_state_nx = ST_IDLE;
        endcase
    end

    // Arming requires a synchronised inactive select after reset, so a reset
    // inside a frame does not resume mid-word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sclk_s1 <= CPOL;    r_sclk_s2 <= CPOL;    r_sclk_d <= CPOL;
            r_ss_s1   <= SS_IDLE; r_ss_s2   <= SS_IDLE;
            r_mosi_s1 <= 1'b0;    r_mosi_s2 <= 1'b0;
            r_sync_ok <= '0;
            r_armed   <= 1'b0;
        end else begin
            r_sclk_s1 <= sclk;    r_sclk_s2 <= r_sclk_s1; r_sclk_d <= r_sclk_s2;
            r_ss_s1   <= ss;      r_ss_s2   <= r_ss_s1;
            r_mosi_s1 <= mosi;    r_mosi_s2 <= r_mosi_s1;
            r_sync_ok <= {r_sync_ok[0], 1'b1};
            r_armed   <= r_armed | (r_sync_ok[1] & ~w_sel);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bit_cnt    <= '0;
            r_words_done <= 1'b0;
            r_rx_sh      <= '0;
            rx_data      <= '0;
            rx_valid     <= 1'b0;
            r_tx_sh      <= '0;
            r_tx_buf     <= '0;
            tx_ready     <= 1'b1;
            r_miso       <= 1'b0;
            r_irq        <= 1'b0;
            rx_overrun   <= 1'b0;
            tx_underrun  <= 1'b0;
            frame_abort  <= 1'b0;
        end else begin
            if (w_enter || w_exit)  r_bit_cnt <= '0;
            else if (w_do_sample)   r_bit_cnt <= w_word_end ? '0 : r_bit_cnt + CW'(1);

            if (w_enter)            r_words_done <= 1'b0;
            else if (w_word_end)    r_words_done <= 1'b1;

            if (w_do_sample) r_rx_sh <= w_rx_next;
            if (w_word_end)  rx_data <= w_rx_next;

            if (w_word_end)  rx_valid <= 1'b1;
            else if (rx_ack) rx_valid <= 1'b0;

            if (w_word_start) begin
                r_tx_sh <= w_tx_word;
                r_miso  <= first_bit(w_tx_word);
            end else if (w_do_shift) begin
                r_tx_sh <= w_tx_shifted;
                r_miso  <= first_bit(w_tx_shifted);
            end else if (w_exit) begin
                r_miso  <= 1'b0;
            end

            if (tx_load && (tx_ready || w_word_start)) begin
                r_tx_buf <= tx_data;
                tx_ready <= 1'b0;
            end else if (w_word_start) begin
                tx_ready <= 1'b1;
            end

            r_irq       <= w_exit & r_words_done;
            rx_overrun  <= (rx_overrun  & ~clr_flags) | (w_word_end & rx_valid & ~rx_ack);
            tx_underrun <= (tx_underrun & ~clr_flags) | (w_word_start & tx_ready);
            frame_abort <= (frame_abort & ~clr_flags) | (w_exit & (r_bit_cnt != '0));
        end
    end

    assign busy    = (r_state == ST_ACTIVE);
    assign miso_oe = busy;
    assign miso    = r_miso;
    assign irq     = r_irq;
endmodule

// File: tb/tb_spi_slave.sv
// Bench for spi_slave: a bit-banged master drives three targets (mode 3/32-bit
// LSB-first, mode 0 and mode 1 8-bit MSB-first) and a word-level model tracks u3.
module tb_spi_slave;
    localparam int H = 6;

    logic clk = 1'b0, rst_n = 1'b0;
    logic sclk = 1'b1, mosi = 1'b0;
    logic ss3 = 1'b0, ss0 = 1'b1, ss1 = 1'b0;

    logic [31:0] tx_data3 = '0, rxd3;
    logic        tx_load3 = 1'b0, rx_ack3 = 1'b0, clr3 = 1'b0;
    logic        miso3, oe3, txr3, rxv3, busy3, irq3, ovr3, und3, abt3;

    logic [7:0]  tx_data8 = '0, rxd0, rxd1;
    logic        tx_load8 = 1'b0, rx_ack8 = 1'b0, clr8 = 1'b0;
    logic        miso0, oe0, txr0, rxv0, busy0, irq0, ovr0, und0, abt0;
    logic        miso1, oe1, txr1, rxv1, busy1, irq1, ovr1, und1, abt1;

    int n_chk = 0, n_err = 0, irq_cnt3 = 0;
    logic chk_en = 1'b0;

    // word-level model of u3
    logic [31:0] m_buf = '0, m_rxd = '0;
    logic        m_txr = 1'b1, m_rxv = 1'b0, m_ovr = 1'b0, m_und = 1'b0, m_abt = 1'b0;
    int          m_irq = 0;

    always #5 clk = ~clk;

    spi_slave #(.MODE(3), .DATA_WIDTH(32), .MSB_FIRST(0), .SS_ACTIVE_LOW(0), .MIN_HALF(4)) u3 (
        .clk(clk), .rst_n(rst_n), .sclk(sclk), .mosi(mosi), .ss(ss3), .miso(miso3), .miso_oe(oe3),
        .tx_data(tx_data3), .tx_load(tx_load3), .tx_ready(txr3), .rx_data(rxd3), .rx_valid(rxv3),
        .rx_ack(rx_ack3), .clr_flags(clr3), .busy(busy3), .irq(irq3), .rx_overrun(ovr3),
        .tx_underrun(und3), .frame_abort(abt3));

    spi_slave #(.MODE(0), .DATA_WIDTH(8), .MSB_FIRST(1), .SS_ACTIVE_LOW(1), .MIN_HALF(4)) u0 (
        .clk(clk), .rst_n(rst_n), .sclk(sclk), .mosi(mosi), .ss(ss0), .miso(miso0), .miso_oe(oe0),
        .tx_data(tx_data8), .tx_load(tx_load8), .tx_ready(txr0), .rx_data(rxd0), .rx_valid(rxv0),
        .rx_ack(rx_ack8), .clr_flags(clr8), .busy(busy0), .irq(irq0), .rx_overrun(ovr0),
        .tx_underrun(und0), .frame_abort(abt0));

    spi_slave #(.MODE(1), .DATA_WIDTH(8), .MSB_FIRST(1), .SS_ACTIVE_LOW(0), .MIN_HALF(4)) u1 (
        .clk(clk), .rst_n(rst_n), .sclk(sclk), .mosi(mosi), .ss(ss1), .miso(miso1), .miso_oe(oe1),
        .tx_data(tx_data8), .tx_load(tx_load8), .tx_ready(txr1), .rx_data(rxd1), .rx_valid(rxv1),
        .rx_ack(rx_ack8), .clr_flags(clr8), .busy(busy1), .irq(irq1), .rx_overrun(ovr1),
        .tx_underrun(und1), .frame_abort(abt1));

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // model actions
    task automatic m_load(input logic [31:0] v);
        if (m_txr) begin m_buf = v; m_txr = 1'b0; end
    endtask
    task automatic m_start(output logic [31:0] wd);
        wd = m_txr ? 32'h0 : m_buf;
        if (m_txr) m_und = 1'b1;
        m_txr = 1'b1;
    endtask
    task automatic m_word(input logic [31:0] v);
        if (m_rxv) m_ovr = 1'b1;
        m_rxd = v;
        m_rxv = 1'b1;
    endtask
    task automatic m_frame_end(input int nbits);
        if (nbits % 32 != 0) m_abt = 1'b1;
        if (nbits >= 32)     m_irq++;
    endtask
    task automatic m_reset();
        m_buf = '0; m_rxd = '0; m_txr = 1'b1; m_rxv = 1'b0;
        m_ovr = 1'b0; m_und = 1'b0; m_abt = 1'b0;
    endtask

    always @(negedge clk) if (irq3) irq_cnt3++;

    always @(negedge clk) begin
        if (chk_en) begin
            chk("rx_data",     {32'h0, rxd3}, {32'h0, m_rxd});
            chk("rx_valid",    {63'h0, rxv3}, {63'h0, m_rxv});
            chk("tx_ready",    {63'h0, txr3}, {63'h0, m_txr});
            chk("rx_overrun",  {63'h0, ovr3}, {63'h0, m_ovr});
            chk("tx_underrun", {63'h0, und3}, {63'h0, m_und});
            chk("frame_abort", {63'h0, abt3}, {63'h0, m_abt});
            chk("idle_oe",     {62'h0, oe3, busy3}, 64'h0);
            chk("idle_miso",   {63'h0, miso3}, 64'h0);
            chk("irq_count",   64'(irq_cnt3), 64'(m_irq));
        end
    end

    task automatic settle();
        @(posedge clk); chk_en = 1'b1;
        repeat (3) @(posedge clk);
        chk_en = 1'b0;
    endtask

    function automatic logic miso_of(input int tgt);
        return (tgt == 3) ? miso3 : (tgt == 0) ? miso0 : miso1;
    endfunction

    task automatic set_ss(input int tgt, input logic act);
        if (tgt == 3)      ss3 = act;
        else if (tgt == 0) ss0 = ~act;
        else               ss1 = act;
    endtask

    // Bit-banged master; word k occupies mo/mi bits [k*W +: W].
    task automatic xfer(input int tgt, input int nbits, input logic [63:0] mo,
                        input int load_at, input logic [31:0] load_val, output logic [63:0] mi);
        logic cpol, cpha, msb;
        int w, idx;
        cpol = (tgt == 3); cpha = (tgt != 0); msb = (tgt != 3); w = (tgt == 3) ? 32 : 8;
        mi = '0;
        @(negedge clk); sclk = cpol; mosi = 1'b0;
        repeat (4) @(negedge clk);
        set_ss(tgt, 1'b1);
        repeat (6) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            idx = (i / w) * w + (msb ? (w - 1 - i % w) : (i % w));
            if (i == load_at) begin
                tx_data3 = load_val; tx_load3 = 1'b1;
                @(negedge clk); tx_load3 = 1'b0;
            end
            if (!cpha) begin
                mosi = mo[idx];
                repeat (H) @(negedge clk);
                mi[idx] = miso_of(tgt);
                sclk = ~cpol;
                repeat (H) @(negedge clk);
                sclk = cpol;
            end else begin
                sclk = ~cpol; mosi = mo[idx];
                repeat (H) @(negedge clk);
                mi[idx] = miso_of(tgt);
                sclk = cpol;
                repeat (H) @(negedge clk);
            end
        end
        repeat (H) @(negedge clk);
        set_ss(tgt, 1'b0);
        repeat (8) @(negedge clk);
    endtask

    task automatic load3(input logic [31:0] v);
        @(negedge clk); tx_data3 = v; tx_load3 = 1'b1;
        @(negedge clk); tx_load3 = 1'b0;
        m_load(v);
    endtask
    task automatic ack3();
        @(negedge clk); rx_ack3 = 1'b1;
        @(negedge clk); rx_ack3 = 1'b0;
        m_rxv = 1'b0;
    endtask
    task automatic clr3_pulse();
        @(negedge clk); clr3 = 1'b1;
        @(negedge clk); clr3 = 1'b0;
        m_ovr = 1'b0; m_und = 1'b0; m_abt = 1'b0;
    endtask

    task automatic chk_reset_vals(input string nm);
        chk({nm, "_rx_data"}, {32'h0, rxd3}, 64'h0);
        chk({nm, "_outs"}, {55'h0, miso3, oe3, txr3, rxv3, busy3, irq3, ovr3, und3, abt3},
            {55'h0, 9'b001000000});
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [63:0] mi;
        logic [31:0] e0, e1;
        repeat (3) @(negedge clk);
        chk_reset_vals("por");
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // one full frame, preloaded tx word
        load3(32'hA5A5_0F0F);
        xfer(3, 32, 64'h1234_5678, -1, 32'h0, mi);
        m_start(e0); m_word(32'h1234_5678); m_frame_end(32);
        chk("t1_miso", mi, {32'h0, e0});
        chk("t1_miso_lit", mi, 64'hA5A5_0F0F);
        chk("t1_rx_lit", {32'h0, rxd3}, 64'h1234_5678);
        settle();

        // two words, second tx word loaded mid-word, no ack between words
        ack3();
        load3(32'h1111_2222);
        xfer(3, 64, 64'hCAFE_BABE_DEAD_BEEF, 10, 32'h3333_4444, mi);
        m_start(e0); m_word(32'hDEAD_BEEF);
        m_load(32'h3333_4444);
        m_start(e1); m_word(32'hCAFE_BABE); m_frame_end(64);
        chk("t2_miso", mi, {e1, e0});
        chk("t2_miso_lit", mi, 64'h3333_4444_1111_2222);
        chk("t2_ovr_lit", {32'h0, ovr3, rxd3[30:0]}, {32'h0, 1'b1, 31'h4AFE_BABE});
        settle();

        // underrun: no tx_load
        clr3_pulse(); ack3();
        xfer(3, 32, 64'h0F0F_0F0F, -1, 32'h0, mi);
        m_start(e0); m_word(32'h0F0F_0F0F); m_frame_end(32);
        chk("t3_miso_lit", mi, 64'h0);
        chk("t3_und_lit", {63'h0, und3}, 64'h1);
        settle();
        clr3_pulse();
        chk("t3_und_clr_lit", {63'h0, und3}, 64'h0);
        settle();

        // abort after 13 bits, then a clean frame
        ack3();
        xfer(3, 13, 64'hFFFF_FFFF, -1, 32'h0, mi);
        m_start(e0); m_frame_end(13);
        chk("t4_abort_lit", {62'h0, abt3, rxv3}, 64'h2);
        settle();
        load3(32'h55AA_55AA);
        xfer(3, 32, 64'h8765_4321, -1, 32'h0, mi);
        m_start(e0); m_word(32'h8765_4321); m_frame_end(32);
        chk("t4_miso", mi, {32'h0, e0});
        chk("t4_rx_lit", {32'h0, rxd3}, 64'h8765_4321);
        settle();

        // reset pulsed mid-word
        fork
            xfer(3, 32, 64'hFFFF_0000, -1, 32'h0, mi);
            begin
                repeat (150) @(negedge clk);
                rst_n = 1'b0;
                @(negedge clk);
                chk_reset_vals("midrst");
                repeat (2) @(negedge clk);
                rst_n = 1'b1;
            end
        join
        m_reset();
        settle();
        load3(32'h0BAD_F00D);
        xfer(3, 32, 64'h600D_CAFE, -1, 32'h0, mi);
        m_start(e0); m_word(32'h600D_CAFE); m_frame_end(32);
        chk("t5_miso", mi, {32'h0, e0});
        chk("t5_rx_lit", {32'h0, rxd3}, 64'h600D_CAFE);
        settle();

        // mode 0 and mode 1, 8-bit MSB-first
        @(negedge clk); tx_data8 = 8'h3C; tx_load8 = 1'b1;
        @(negedge clk); tx_load8 = 1'b0;
        xfer(0, 8, 64'h3C, -1, 32'h0, mi);
        chk("m0_miso", mi, 64'h3C);
        chk("m0_rx", {55'h0, rxv0, rxd0}, {55'h0, 1'b1, 8'h3C});
        xfer(1, 8, 64'h3C, -1, 32'h0, mi);
        chk("m1_miso", mi, 64'h3C);
        chk("m1_rx", {55'h0, rxv1, rxd1}, {55'h0, 1'b1, 8'h3C});

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
